pll_lock_detector: RTL and testbench

Lock detector for the event-driven phase-locked loop, sitting directly downstream of the phase-frequency detector. It samples the PFD up/down pulses and the reference clock on the simulator clock and measures the signed phase error of every reference period. It asserts a lock flag after a run of in-tolerance periods and drops it after a run of out-of-tolerance periods or a missing reference. Lock/unlock hysteresis keeps the flag stable against isolated glitches.

---
 rtl/pll_pkg.sv | 29 ++
 rtl/phase_error_accumulator.sv | 61 ++++++
 rtl/pll_lock_detector.sv | 151 +++++++++++++++
 tb/tb_pll_lock_detector.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL lock detector: FSM state encoding,
// saturation limits of the signed phase-error measurement and the tolerance test.
package pll_pkg;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        ACQUIRING = 2'd1,
        LOCKED    = 2'd2,
        SLIPPING  = 2'd3
    } lock_state_t;

    localparam int PLL_ERR_WIDTH = 8;
    localparam int PLL_ERR_MAX   = (1 << (PLL_ERR_WIDTH - 1)) - 1;
    localparam int PLL_ERR_MIN   = -(1 << (PLL_ERR_WIDTH - 1));

    function automatic int err_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int err_min(input int width);
        return -(1 << (width - 1));
    endfunction

    // Signed window test; the most negative code can never pass because its magnitude is unrepresentable.
    function automatic logic within_tolerance(input int err, input int tol);
        return (err <= tol) && (err >= -tol);
    endfunction

endpackage

// File: rtl/phase_error_accumulator.sv
// Signed saturating up/down accumulator of PFD activity; restarts on each reference
// edge and optionally publishes the completed period's error with a one-cycle valid.
module phase_error_accumulator #(
    parameter int ERR_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        up,
    input  logic                        down,
    input  logic                        sample,
    input  logic                        publish,
    output logic signed [ERR_WIDTH-1:0] acc,
    output logic signed [ERR_WIDTH-1:0] error,
    output logic                        error_valid
);

    localparam logic signed [ERR_WIDTH-1:0] ACC_MAX = {1'b0, {(ERR_WIDTH-1){1'b1}}};
    localparam logic signed [ERR_WIDTH-1:0] ACC_MIN = {1'b1, {(ERR_WIDTH-1){1'b0}}};
    localparam logic signed [ERR_WIDTH-1:0] ONE     = {{(ERR_WIDTH-1){1'b0}}, 1'b1};

    logic                        inc;
    logic                        dec;
    logic signed [ERR_WIDTH-1:0] contrib;
    logic signed [ERR_WIDTH-1:0] acc_next;

    // Up and down together is the PFD reset overlap and contributes nothing.
    assign inc = up & ~down;
    assign dec = down & ~up;

    always_comb begin
        contrib  = '0;
        acc_next = acc;
        if (inc) begin
            contrib = ONE;
            if (acc != ACC_MAX) acc_next = acc + ONE;
        end else if (dec) begin
            contrib = '1;
            if (acc != ACC_MIN) acc_next = acc - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc         <= '0;
            error       <= '0;
            error_valid <= 1'b0;
        end else begin
            error_valid <= 1'b0;
            if (sample) begin
                acc <= contrib;
                if (publish) begin
                    error       <= acc;
                    error_valid <= 1'b1;
                end
            end else begin
                acc <= acc_next;
            end
        end
    end

endmodule

// File: rtl/pll_lock_detector.sv
// Lock detector downstream of the PFD: per-reference-period phase error, lock/unlock
// hysteresis FSM and a missing-reference timeout. State is exposed on state_dbg.
module pll_lock_detector
    import pll_pkg::*;
#(
    parameter int ERR_WIDTH      = PLL_ERR_WIDTH,
    parameter int LOCK_TOLERANCE = 2,
    parameter int LOCK_COUNT     = 16,
    parameter int UNLOCK_COUNT   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        reference_clk_digital,
    input  logic                        input_up_digital,
    input  logic                        input_down_digital,
    output logic                        output_lock_digital,
    output logic signed [ERR_WIDTH-1:0] output_phase_error,
    output logic                        output_error_valid,
    output logic                        output_timeout,
    output lock_state_t                 state_dbg
);

    localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int GAP_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0] LOCK_N   = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0] UNLOCK_N = RUN_W'(UNLOCK_COUNT);
    localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    lock_state_t                 state;
    logic                        ref_q;
    logic                        ref_edge;
    logic                        first_edge;
    logic [RUN_W-1:0]            run_cnt;
    logic [RUN_W-1:0]            run_inc;
    logic [GAP_W-1:0]            gap_cnt;
    logic                        timeout_fire;
    logic                        good;
    logic signed [ERR_WIDTH-1:0] err_acc;

    assign ref_edge     = reference_clk_digital & ~ref_q;
    assign timeout_fire = ~ref_edge && (gap_cnt == GAP_LAST);
    assign good         = within_tolerance(int'(err_acc), LOCK_TOLERANCE);
    assign run_inc      = (run_cnt == RUN_SAT) ? run_cnt : run_cnt + 1'b1;
    assign state_dbg    = state;

    phase_error_accumulator #(
        .ERR_WIDTH(ERR_WIDTH)
    ) u_acc (
        .clk        (clk),
        .reset      (reset),
        .up         (input_up_digital),
        .down       (input_down_digital),
        .sample     (ref_edge),
        .publish    (ref_edge & ~first_edge),
        .acc        (err_acc),
        .error      (output_phase_error),
        .error_valid(output_error_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_q               <= 1'b0;
            state               <= UNLOCKED;
            run_cnt             <= '0;
            gap_cnt             <= '0;
            first_edge          <= 1'b1;
            output_lock_digital <= 1'b0;
            output_timeout      <= 1'b0;
        end else begin
            ref_q <= reference_clk_digital;

            if (ref_edge)                gap_cnt <= '0;
            else if (gap_cnt != GAP_FULL) gap_cnt <= gap_cnt + 1'b1;

            if (timeout_fire) begin
                // The next edge after a lost reference only re-primes the accumulator.
                state               <= UNLOCKED;
                run_cnt             <= '0;
                output_lock_digital <= 1'b0;
                output_timeout      <= 1'b1;
                first_edge          <= 1'b1;
            end else if (ref_edge) begin
                first_edge     <= 1'b0;
                output_timeout <= 1'b0;
                if (!first_edge) begin
                    case (state)
                        UNLOCKED: begin
                            if (good) begin
                                if (LOCK_N <= 1) begin
                                    state               <= LOCKED;
                                    run_cnt             <= '0;
                                    output_lock_digital <= 1'b1;
                                end else begin
                                    state   <= ACQUIRING;
                                    run_cnt <= RUN_W'(1);
                                end
                            end
                        end
                        ACQUIRING: begin
                            if (!good) begin
                                state   <= UNLOCKED;
                                run_cnt <= '0;
                            end else if (run_inc >= LOCK_N) begin
                                state               <= LOCKED;
                                run_cnt             <= '0;
                                output_lock_digital <= 1'b1;
                            end else begin
                                run_cnt <= run_inc;
                            end
                        end
                        LOCKED: begin
                            if (!good) begin
                                if (UNLOCK_N <= 1) begin
                                    state               <= UNLOCKED;
                                    run_cnt             <= '0;
                                    output_lock_digital <= 1'b0;
                                end else begin
                                    state   <= SLIPPING;
                                    run_cnt <= RUN_W'(1);
                                end
                            end
                        end
                        SLIPPING: begin
                            if (good) begin
                                state   <= LOCKED;
                                run_cnt <= '0;
                            end else if (run_inc >= UNLOCK_N) begin
                                state               <= UNLOCKED;
                                run_cnt             <= '0;
                                output_lock_digital <= 1'b0;
                            end else begin
                                run_cnt <= run_inc;
                            end
                        end
                        default: begin
                            state               <= UNLOCKED;
                            run_cnt             <= '0;
                            output_lock_digital <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_detector.sv
// Directed bench for pll_lock_detector: acquisition, slip/unlock, glitch hysteresis,
// saturation, reference timeout and asynchronous reset during acquisition.
module tb_pll_lock_detector;
    import pll_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ref_clk = 1'b0;
    logic        up = 1'b0;
    logic        dn = 1'b0;
    logic        lock;
    logic [7:0]  phase_err;
    logic        err_valid;
    logic        timeout;
    lock_state_t state_dbg;

    int n_vec = 0;
    int n_err = 0;

    logic        cap_valid;
    logic [7:0]  cap_err;
    logic        cap_lock;
    logic        cap_timeout;
    lock_state_t cap_state;

    pll_lock_detector #(
        .ERR_WIDTH(8), .LOCK_TOLERANCE(2), .LOCK_COUNT(16),
        .UNLOCK_COUNT(4), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .reference_clk_digital(ref_clk),
        .input_up_digital     (up),
        .input_down_digital   (dn),
        .output_lock_digital  (lock),
        .output_phase_error   (phase_err),
        .output_error_valid   (err_valid),
        .output_timeout       (timeout),
        .state_dbg            (state_dbg)
    );

    always #5 clk = ~clk;

    // One reference period: low_len cycles low (pulses start at cycle 10), rising edge,
    // outputs captured just after the edge is sampled, then 49 cycles high.
    task automatic ref_period(input int low_len, input int up_len, input int dn_len);
        for (int i = 0; i < low_len; i++) begin
            @(negedge clk);
            ref_clk = 1'b0;
            up = (i >= 10) && (i < 10 + up_len);
            dn = (i >= 10) && (i < 10 + dn_len);
        end
        @(negedge clk);
        ref_clk = 1'b1; up = 1'b0; dn = 1'b0;
        @(posedge clk); #1;
        cap_valid = err_valid; cap_err = phase_err; cap_lock = lock;
        cap_timeout = timeout; cap_state = state_dbg;
        for (int i = 0; i < 49; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL reset_lock: got %0b want 0", lock); end
        n_vec++; if (phase_err !== 8'h00) begin n_err++; $display("FAIL reset_err: got %h want 00", phase_err); end
        n_vec++; if (err_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", err_valid); end
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
        n_vec++; if (state_dbg !== UNLOCKED) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state_dbg, UNLOCKED); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_acquire();
        ref_period(50, 0, 0);
        n_vec++; if (cap_valid !== 1'b0) begin n_err++; $display("FAIL acq_edge1_valid: got %0b want 0", cap_valid); end
        for (int k = 2; k <= 17; k++) begin
            ref_period(50, 0, 0);
            n_vec++; if (cap_valid !== 1'b1) begin n_err++; $display("FAIL acq_valid e%0d: got %0b want 1", k, cap_valid); end
            n_vec++; if (cap_err !== 8'h00) begin n_err++; $display("FAIL acq_err e%0d: got %h want 00", k, cap_err); end
            n_vec++; if (cap_lock !== (k == 17)) begin n_err++; $display("FAIL acq_lock e%0d: got %0b want %0b", k, cap_lock, k == 17); end
            n_vec++; if (cap_state !== ((k == 17) ? LOCKED : ACQUIRING)) begin
                n_err++; $display("FAIL acq_state e%0d: got %0d want %0d", k, cap_state, (k == 17) ? LOCKED : ACQUIRING); end
            if (k == 2) begin
                n_vec++; if (err_valid !== 1'b0) begin n_err++; $display("FAIL acq_valid_pulse: got %0b want 0", err_valid); end
            end
        end
    endtask

    task automatic test_slip_to_unlock();
        for (int k = 1; k <= 4; k++) begin
            ref_period(50, 5, 0);
            n_vec++; if (cap_err !== 8'h05) begin n_err++; $display("FAIL slip_err p%0d: got %h want 05", k, cap_err); end
            n_vec++; if (cap_lock !== (k < 4)) begin n_err++; $display("FAIL slip_lock p%0d: got %0b want %0b", k, cap_lock, k < 4); end
            n_vec++; if (cap_state !== ((k < 4) ? SLIPPING : UNLOCKED)) begin
                n_err++; $display("FAIL slip_state p%0d: got %0d want %0d", k, cap_state, (k < 4) ? SLIPPING : UNLOCKED); end
        end
        for (int k = 1; k <= 16; k++) begin
            ref_period(50, 0, 0);
            n_vec++; if (cap_lock !== (k == 16)) begin n_err++; $display("FAIL relock_lock p%0d: got %0b want %0b", k, cap_lock, k == 16); end
        end
    endtask

    task automatic test_glitch();
        ref_period(50, 0, 6);
        n_vec++; if (cap_err !== 8'hFA) begin n_err++; $display("FAIL glitch_err: got %h want fa", cap_err); end
        n_vec++; if (cap_lock !== 1'b1) begin n_err++; $display("FAIL glitch_lock: got %0b want 1", cap_lock); end
        n_vec++; if (cap_state !== SLIPPING) begin n_err++; $display("FAIL glitch_state: got %0d want %0d", cap_state, SLIPPING); end
        ref_period(50, 0, 0);
        n_vec++; if (cap_err !== 8'h00) begin n_err++; $display("FAIL glitch_rec_err: got %h want 00", cap_err); end
        n_vec++; if (cap_lock !== 1'b1) begin n_err++; $display("FAIL glitch_rec_lock: got %0b want 1", cap_lock); end
        n_vec++; if (cap_state !== LOCKED) begin n_err++; $display("FAIL glitch_rec_state: got %0d want %0d", cap_state, LOCKED); end
    endtask

    task automatic test_saturation();
        ref_period(350, 300, 0);
        n_vec++; if (cap_err !== 8'h7F) begin n_err++; $display("FAIL sat_pos_err: got %h want 7f", cap_err); end
        n_vec++; if (cap_state !== SLIPPING) begin n_err++; $display("FAIL sat_pos_state: got %0d want %0d", cap_state, SLIPPING); end
        ref_period(350, 0, 300);
        n_vec++; if (cap_err !== 8'h80) begin n_err++; $display("FAIL sat_neg_err: got %h want 80", cap_err); end
        n_vec++; if (cap_valid !== 1'b1) begin n_err++; $display("FAIL sat_neg_valid: got %0b want 1", cap_valid); end
        n_vec++; if (cap_state !== SLIPPING) begin n_err++; $display("FAIL sat_neg_bad: got %0d want %0d", cap_state, SLIPPING); end
        n_vec++; if (cap_lock !== 1'b1) begin n_err++; $display("FAIL sat_neg_lock: got %0b want 1", cap_lock); end
        ref_period(50, 0, 0);
        n_vec++; if (cap_state !== LOCKED) begin n_err++; $display("FAIL sat_relock_state: got %0d want %0d", cap_state, LOCKED); end
    endtask

    task automatic test_timeout();
        int n;
        @(negedge clk); ref_clk = 1'b0;
        @(negedge clk); ref_clk = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (err_valid !== 1'b1 || lock !== 1'b1) begin
            n_err++; $display("FAIL to_last_edge: got valid %0b lock %0b want 1 1", err_valid, lock); end
        @(negedge clk); ref_clk = 1'b0;
        n = 0;
        while (n < 1100 && timeout !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        n_vec++; if (n != 1024) begin n_err++; $display("FAIL to_delay: got %0d cycles want 1024", n); end
        n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL to_flag: got %0b want 1", timeout); end
        n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL to_lock: got %0b want 0", lock); end
        n_vec++; if (state_dbg !== UNLOCKED) begin n_err++; $display("FAIL to_state: got %0d want %0d", state_dbg, UNLOCKED); end
        repeat (20) @(posedge clk);
        #1;
        n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %0b want 1", timeout); end
        ref_period(50, 0, 0);
        n_vec++; if (cap_timeout !== 1'b0) begin n_err++; $display("FAIL to_clear: got %0b want 0", cap_timeout); end
        n_vec++; if (cap_valid !== 1'b0) begin n_err++; $display("FAIL to_prime_valid: got %0b want 0", cap_valid); end
        n_vec++; if (cap_lock !== 1'b0) begin n_err++; $display("FAIL to_prime_lock: got %0b want 0", cap_lock); end
        ref_period(50, 0, 0);
        n_vec++; if (cap_valid !== 1'b1) begin n_err++; $display("FAIL to_resume_valid: got %0b want 1", cap_valid); end
        n_vec++; if (cap_state !== ACQUIRING) begin n_err++; $display("FAIL to_resume_state: got %0d want %0d", cap_state, ACQUIRING); end
    endtask

    task automatic test_reset_mid_acquire();
        for (int k = 2; k <= 10; k++) ref_period(50, 2, 0);
        n_vec++; if (cap_err !== 8'h02) begin n_err++; $display("FAIL rst_pre_err: got %h want 02", cap_err); end
        n_vec++; if (cap_state !== ACQUIRING) begin n_err++; $display("FAIL rst_pre_state: got %0d want %0d", cap_state, ACQUIRING); end
        @(negedge clk); ref_clk = 1'b0; up = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL rst_async_lock: got %0b want 0", lock); end
        n_vec++; if (phase_err !== 8'h00) begin n_err++; $display("FAIL rst_async_err: got %h want 00", phase_err); end
        n_vec++; if (err_valid !== 1'b0 || timeout !== 1'b0) begin
            n_err++; $display("FAIL rst_async_flags: got valid %0b timeout %0b want 0 0", err_valid, timeout); end
        n_vec++; if (state_dbg !== UNLOCKED) begin n_err++; $display("FAIL rst_async_state: got %0d want %0d", state_dbg, UNLOCKED); end
        @(negedge clk); up = 1'b0; reset = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            ref_period(50, 0, 0);
            if (k == 1) begin
                n_vec++; if (cap_valid !== 1'b0) begin n_err++; $display("FAIL rst_prime_valid: got %0b want 0", cap_valid); end
            end
            if (k >= 16) begin
                n_vec++; if (cap_lock !== (k == 17)) begin n_err++; $display("FAIL rst_relock e%0d: got %0b want %0b", k, cap_lock, k == 17); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_slip_to_unlock();
        test_glitch();
        test_saturation();
        test_timeout();
        test_reset_mid_acquire();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation time limit want normal completion");
        $fatal(1);
    end

endmodule
